if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline. It sits directly upstream of npc. It owns the PC register and exports pc_add_4 to npc, then loads the npc result back into the PC. It drives a request/acknowledge instruction-memory port and produces the IF/ID pipeline register. It handles data-hazard holds, control-hazard flushes and multi-cycle memory waits, including a flush that arrives while a fetch is still outstanding.

---
 rtl/if_stage.sv | 129 ++++++++++++
 tb/tb_if_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the req/ack instruction-memory port and
// produces the IF/ID pipeline register, including drain of a fetch squashed mid-flight.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      npc,
    input  logic             ifid_hold,
    input  logic             ifid_flush,
    output logic [31:0]      pc,
    output logic [31:0]      pc_add_4,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc_add_4,
    output logic             if_id_valid,
    output logic             fetch_busy,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef enum logic [1:0] {
        StBoot,
        StFetch,
        StDrain
    } state_e;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e             state_q;
    logic [31:0]        pc_q;
    logic [31:0]        redirect_pc_q;
    logic [31:0]        if_id_instr_q;
    logic [31:0]        if_id_pc_add_4_q;
    logic               if_id_valid_q;
    logic [CNT_W-1:0]   fetch_cnt_q;
    logic [CNT_W-1:0]   bubble_cnt_q;

    logic [31:0]        npc_aligned;
    logic [31:0]        pc_plus_4;
    logic               unused_npc_bits;

    assign npc_aligned     = {npc[31:2], 2'b00};
    assign unused_npc_bits = ^npc[1:0];
    assign pc_plus_4       = pc_q + 32'd4;

    assign pc             = pc_q;
    assign pc_add_4       = pc_plus_4;
    assign imem_req       = (state_q != StBoot);
    assign imem_addr      = pc_q;
    assign fetch_busy     = imem_req & ~imem_ack;
    assign if_id_instr    = if_id_instr_q;
    assign if_id_pc_add_4 = if_id_pc_add_4_q;
    assign if_id_valid    = if_id_valid_q;
    assign fetch_cnt      = fetch_cnt_q;
    assign bubble_cnt     = bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StBoot;
            pc_q             <= {RESET_PC[31:2], 2'b00};
            redirect_pc_q    <= 32'h0;
            if_id_instr_q    <= NOP_INSTR;
            if_id_pc_add_4_q <= 32'h0;
            if_id_valid_q    <= 1'b0;
            fetch_cnt_q      <= '0;
            bubble_cnt_q     <= '0;
        end else begin
            unique case (state_q)
                StBoot: begin
                    state_q <= StFetch;
                end

                StFetch: begin
                    if (ifid_flush) begin
                        if_id_instr_q <= NOP_INSTR;
                        if_id_valid_q <= 1'b0;
                        bubble_cnt_q  <= bubble_cnt_q + CntOne;
                        if (imem_ack) begin
                            pc_q <= npc_aligned;
                        end else begin
                            // Memory cannot abort: park the target until the old fetch returns.
                            redirect_pc_q <= npc_aligned;
                            state_q       <= StDrain;
                        end
                    end else if (ifid_hold) begin
                        if (imem_ack) begin
                            pc_q <= npc_aligned;
                        end
                    end else if (imem_ack) begin
                        if_id_instr_q    <= imem_rdata;
                        if_id_pc_add_4_q <= pc_plus_4;
                        if_id_valid_q    <= 1'b1;
                        fetch_cnt_q      <= fetch_cnt_q + CntOne;
                        pc_q             <= npc_aligned;
                    end else begin
                        if_id_instr_q <= NOP_INSTR;
                        if_id_valid_q <= 1'b0;
                        bubble_cnt_q  <= bubble_cnt_q + CntOne;
                    end
                end

                StDrain: begin
                    if_id_instr_q <= NOP_INSTR;
                    if_id_valid_q <= 1'b0;
                    bubble_cnt_q  <= bubble_cnt_q + CntOne;
                    if (ifid_flush) begin
                        redirect_pc_q <= npc_aligned;
                    end
                    if (imem_ack) begin
                        // A flush coinciding with the ack is the newest redirect and wins.
                        pc_q    <= ifid_flush ? npc_aligned : redirect_pc_q;
                        state_q <= StFetch;
                    end
                end

                default: begin
                    state_q <= StBoot;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a cycle-level reference model queues expectations and
// a monitor on the falling edge compares them against the DUT.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic [31:0] npc;
    logic        ifid_hold;
    logic        ifid_flush;
    logic [31:0] pc;
    logic [31:0] pc_add_4;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_add_4;
    logic        if_id_valid;
    logic        fetch_busy;
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;

    if_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000),
        .CNT_W     (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .npc            (npc),
        .ifid_hold      (ifid_hold),
        .ifid_flush     (ifid_flush),
        .pc             (pc),
        .pc_add_4       (pc_add_4),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_id_instr    (if_id_instr),
        .if_id_pc_add_4 (if_id_pc_add_4),
        .if_id_valid    (if_id_valid),
        .fetch_busy     (fetch_busy),
        .fetch_cnt      (fetch_cnt),
        .bubble_cnt     (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pa4;
        logic        req;
        logic        busy;
        logic [31:0] instr;
        logic [31:0] ipa4;
        logic        valid;
        logic [31:0] fcnt;
        logic [31:0] bcnt;
    } rec_t;

    rec_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: where the stage is in its life, not how the RTL encodes it.
    bit          m_init = 0;
    bit          m_booting;
    bit          m_draining;
    logic [31:0] m_pc, m_redir, m_instr, m_ipa4, m_fcnt, m_bcnt;
    logic        m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_bubble();
        m_instr = 32'h0;
        m_valid = 1'b0;
        m_bcnt  = m_bcnt + 1;
    endtask

    // One clock of stimulus; expectations for this cycle are queued before the model advances.
    task automatic cycle(input bit r, input bit a, input logic [31:0] d, input logic [31:0] n,
                         input bit h, input bit f);
        rec_t e;
        logic [31:0] tgt;
        @(posedge clk);
        #1;
        rst = r; imem_ack = a; imem_rdata = d; npc = n; ifid_hold = h; ifid_flush = f;
        tgt = n & 32'hFFFF_FFFC;
        if (m_init) begin
            e.pc = m_pc; e.pa4 = m_pc + 32'd4;
            e.req = !m_booting; e.busy = !m_booting && !a;
            e.instr = m_instr; e.ipa4 = m_ipa4; e.valid = m_valid;
            e.fcnt = m_fcnt; e.bcnt = m_bcnt;
            q.push_back(e);
        end
        if (r) begin
            m_init = 1; m_booting = 1; m_draining = 0;
            m_pc = 32'h0; m_redir = 32'h0; m_instr = 32'h0; m_ipa4 = 32'h0;
            m_valid = 0; m_fcnt = 0; m_bcnt = 0;
        end else if (!m_init) begin
            // DUT state undefined before the first reset
        end else if (m_booting) begin
            m_booting = 0;
        end else if (m_draining) begin
            model_bubble();
            if (f) m_redir = tgt;
            if (a) begin
                m_pc = m_redir;
                m_draining = 0;
            end
        end else if (f) begin
            model_bubble();
            if (a) m_pc = tgt;
            else begin
                m_redir = tgt;
                m_draining = 1;
            end
        end else if (h) begin
            if (a) m_pc = tgt;
        end else if (a) begin
            m_instr = d; m_ipa4 = m_pc + 32'd4; m_valid = 1;
            m_fcnt = m_fcnt + 1;
            m_pc = tgt;
        end else begin
            model_bubble();
        end
    endtask

    // Monitor: one record per cycle, compared mid-cycle after inputs have settled.
    initial begin
        rec_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc", pc, e.pc);
                chk("imem_addr", imem_addr, e.pc);
                chk("pc_add_4", pc_add_4, e.pa4);
                chk("imem_req", {31'b0, imem_req}, {31'b0, e.req});
                chk("fetch_busy", {31'b0, fetch_busy}, {31'b0, e.busy});
                chk("if_id_instr", if_id_instr, e.instr);
                chk("if_id_pc_add_4", if_id_pc_add_4, e.ipa4);
                chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.valid});
                chk("fetch_cnt", fetch_cnt, e.fcnt);
                chk("bubble_cnt", bubble_cnt, e.bcnt);
            end
        end
    end

    initial begin
        logic [31:0] n;
        bit a, h, f, r;
        rst = 1; imem_ack = 0; imem_rdata = 0; npc = 0; ifid_hold = 0; ifid_flush = 0;

        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 1, 32'hDEAD_BEEF, 0, 0, 0);
        cycle(0, 1, 32'hBAD0_0000, 32'h40, 0, 0);         // BOOT: ack ignored
        // Zero-wait streaming 0x0, 0x4, 0x8, 0xC
        for (int i = 0; i < 4; i++) cycle(0, 1, 32'h1000 + i, m_pc + 4, 0, 0);
        // Two wait states at 0x10
        cycle(0, 0, 0, 32'h77, 0, 0);
        cycle(0, 0, 0, 32'h77, 0, 0);
        cycle(0, 1, 32'hAAAA_0010, m_pc + 4, 0, 0);
        cycle(0, 1, 32'hAAAA_0014, 32'h20, 0, 0);
        // Hold with ack, npc = pc, then re-fetch
        cycle(0, 1, 32'hBBBB_0020, m_pc, 1, 0);
        cycle(0, 1, 32'hCCCC_0020, 32'h30, 0, 0);
        // Flush with ack at 0x30
        cycle(0, 1, 32'hDDDD_0030, 32'h100, 0, 1);
        cycle(0, 1, 32'h0000_0100, 32'h40, 0, 0);
        // Flush without ack at 0x40; ack two cycles later
        cycle(0, 0, 0, 32'h200, 0, 1);
        cycle(0, 0, 0, 32'h300, 1, 0);
        cycle(0, 1, 32'hEEEE_0040, 32'h500, 0, 0);
        cycle(0, 1, 32'h0000_0200, 32'h204, 0, 0);
        // Reset during a DRAIN wait, then a stray ack in BOOT
        cycle(0, 0, 0, 32'h600, 0, 1);
        cycle(0, 0, 0, 32'h0, 0, 0);
        cycle(1, 0, 0, 32'h0, 0, 0);
        cycle(0, 1, 32'h1234_5678, 32'h8, 0, 0);
        cycle(0, 1, 32'h1111_0000, 32'h4, 0, 0);

        // Randomized traffic, including unaligned npc and occasional reset
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 249) == 0);
            a = ($urandom_range(0, 9) < 6);
            h = ($urandom_range(0, 9) < 2);
            f = ($urandom_range(0, 9) == 0);
            n = ($urandom_range(0, 9) < 7) ? m_pc + 32'd4 : $urandom;
            cycle(r, a, $urandom, n, h, f);
        end

        for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
